// File: rtl/io_bus_arb_if.sv
// Signal bundle for the shared IO bus: two requesting masters on one side,
// the dma_io peripheral chain on the other. The arbiter uses the slave
// view. The master view is for whoever drives the requests and returns
// peripheral read data (masters plus the peripheral chain).
interface io_bus_arb_if #(
  parameter int ADR_W  = 14,
  parameter int DATA_W = 32
);
  // Master 0 (CPU load/store path)
  logic              m0_req;
  logic              m0_we;
  logic [ADR_W-1:0]  m0_adr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;

  // Master 1 (UART debug monitor)
  logic              m1_req;
  logic              m1_we;
  logic [ADR_W-1:0]  m1_adr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;

  // Registered command toward the peripherals, daisy-chained read data back
  logic              dma_io_we;
  logic [ADR_W-1:0]  dma_io_wadr;
  logic [DATA_W-1:0] dma_io_wdata;
  logic [ADR_W-1:0]  dma_io_radr;
  logic              dma_io_radr_en;
  logic [DATA_W-1:0] dma_io_rdata;

  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_we, m1_adr, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en,
    input  dma_io_rdata
  );

  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_we, m1_adr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en,
    output dma_io_rdata
  );
endinterface

// File: rtl/io_bus_arb.sv
// Two-master arbiter for the shared IO bus. Grants at most one command per
// cycle (round-robin, or master 0 first when FIXED_PRIO=1). The granted
// command is registered onto dma_io_*. A two-stage {valid, owner} pipeline
// steers the peripheral read data back to the master that issued the read.
module io_bus_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int ADR_W      = 14,
  parameter int DATA_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  io_bus_arb_if.slave bus
);

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              last_gnt;     // 0 = master 0 was granted last, 1 = master 1

  logic              sel_we;
  logic [ADR_W-1:0]  sel_adr;
  logic [DATA_W-1:0] sel_wdata;

  logic              we_p0;
  logic [ADR_W-1:0]  wadr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [ADR_W-1:0]  radr_p0;
  logic              vld_p0;       // read issued on the bus this cycle
  logic              own_p0;
  logic              vld_p1;       // peripheral read data is valid this cycle
  logic              own_p1;

  // Grant decision. Held off while in reset so that no master sees a grant
  // for a command that the held-in-reset registers would drop.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.m0_req && bus.m1_req) begin
        if ((FIXED_PRIO != 0) || last_gnt) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  // Select the granted master's command for registration.
  always_comb begin
    sel_we    = bus.m0_we;
    sel_adr   = bus.m0_adr;
    sel_wdata = bus.m0_wdata;
    if (gnt1) begin
      sel_we    = bus.m1_we;
      sel_adr   = bus.m1_adr;
      sel_wdata = bus.m1_wdata;
    end
  end

  // ---- stage p0: accepted command drives the bus (grant cycle + 1) ----
  // Register the accepted command and track the last granted master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      we_p0    <= 1'b0;
      wadr_p0  <= '0;
      wdata_p0 <= '0;
      radr_p0  <= '0;
      vld_p0   <= 1'b0;
      own_p0   <= 1'b0;
    end else begin
      we_p0  <= any_gnt & sel_we;
      vld_p0 <= any_gnt & ~sel_we;
      own_p0 <= gnt1;
      if (any_gnt) begin
        last_gnt <= gnt1;
      end
      if (any_gnt && sel_we) begin
        wadr_p0  <= sel_adr;
        wdata_p0 <= sel_wdata;
      end
      if (any_gnt && !sel_we) begin
        radr_p0 <= sel_adr;
      end
    end
  end

  // ---- stage p1: peripheral read data returns (grant cycle + 2) ----
  // Carry the read owner forward to line up with the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      own_p1 <= own_p0;
    end
  end

  assign bus.m0_gnt         = gnt0;
  assign bus.m1_gnt         = gnt1;

  assign bus.dma_io_we      = we_p0;
  assign bus.dma_io_wadr    = wadr_p0;
  assign bus.dma_io_wdata   = wdata_p0;
  assign bus.dma_io_radr    = radr_p0;
  assign bus.dma_io_radr_en = vld_p0;

  // Read data fans out to both masters; only rvalid says whose it is.
  assign bus.m0_rdata       = bus.dma_io_rdata;
  assign bus.m1_rdata       = bus.dma_io_rdata;
  assign bus.m0_rvalid      = vld_p1 & ~own_p1;
  assign bus.m1_rvalid      = vld_p1 & own_p1;

endmodule

// File: tb/tb_io_bus_arb.sv
// Bench for io_bus_arb. Two instances run side by side: index 0 is
// round-robin (FIXED_PRIO=0), index 1 is fixed priority (FIXED_PRIO=1).
// A transaction-level model predicts grants, bus commands and read returns.
module tb_io_bus_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // stimulus / observation, indexed [instance][master]
  logic        req   [2][2];
  logic        we    [2][2];
  logic [13:0] adr   [2][2];
  logic [31:0] wd    [2][2];
  logic        gnt   [2][2];
  logic        rv    [2][2];
  logic [31:0] rd    [2][2];
  logic        bwe   [2];
  logic        bren  [2];
  logic [13:0] bwadr [2];
  logic [13:0] bradr [2];
  logic [31:0] bwdata[2];
  logic [31:0] prd   [2];
  logic [31:0] pmem  [2][16];

  io_bus_arb_if #(.ADR_W(14), .DATA_W(32)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].m0_req       = req[g][0];
    assign bus[g].m0_we        = we[g][0];
    assign bus[g].m0_adr       = adr[g][0];
    assign bus[g].m0_wdata     = wd[g][0];
    assign bus[g].m1_req       = req[g][1];
    assign bus[g].m1_we        = we[g][1];
    assign bus[g].m1_adr       = adr[g][1];
    assign bus[g].m1_wdata     = wd[g][1];
    assign bus[g].dma_io_rdata = prd[g];
    assign gnt[g][0]           = bus[g].m0_gnt;
    assign gnt[g][1]           = bus[g].m1_gnt;
    assign rv[g][0]            = bus[g].m0_rvalid;
    assign rv[g][1]            = bus[g].m1_rvalid;
    assign rd[g][0]            = bus[g].m0_rdata;
    assign rd[g][1]            = bus[g].m1_rdata;
    assign bwe[g]              = bus[g].dma_io_we;
    assign bren[g]             = bus[g].dma_io_radr_en;
    assign bwadr[g]            = bus[g].dma_io_wadr;
    assign bradr[g]            = bus[g].dma_io_radr;
    assign bwdata[g]           = bus[g].dma_io_wdata;

    io_bus_arb #(.FIXED_PRIO(g), .ADR_W(14), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
  end

  // Peripheral register file: write lands on the strobe edge, read data
  // is returned one cycle after radr_en. Cleared while in reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        prd[i] <= '0;
        for (int a = 0; a < 16; a++) pmem[i][a] <= '0;
      end else begin
        if (bwe[i])  pmem[i][bwadr[i][3:0]] <= bwdata[i];
        if (bren[i]) prd[i] <= pmem[i][bradr[i][3:0]];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          own;
    logic [31:0] d;
  } ret_t;

  ret_t        rq     [2][$];
  int          last_m [2];
  int          pk     [2];
  logic [31:0] refmem [2][16];
  logic        e_we   [2];
  logic        e_ren  [2];
  logic [13:0] e_wadr [2];
  logic [13:0] e_radr [2];
  logic [31:0] e_wdata[2];
  int          cyc;

  logic        obs_rv [2][2];
  logic [31:0] obs_rd [2][2];
  logic [3:0]  gob;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete();
      last_m[i]  = 1;
      pk[i]      = -1;
      e_we[i]    = 1'b0;
      e_ren[i]   = 1'b0;
      e_wadr[i]  = '0;
      e_radr[i]  = '0;
      e_wdata[i] = '0;
      for (int a = 0; a < 16; a++) refmem[i][a] = '0;
    end
  endtask

  // Who wins this cycle: -1 none. Instance 1 is the fixed-priority one.
  function automatic int pick(input int i);
    if (!rst_n) return -1;
    if (req[i][0] && req[i][1]) return (i == 1) ? 0 : 1 - last_m[i];
    if (req[i][0]) return 0;
    if (req[i][1]) return 1;
    return -1;
  endfunction

  task automatic drive(input int i, input int m, input logic r, input logic w,
                       input logic [13:0] a, input logic [31:0] d);
    req[i][m] = r;
    we[i][m]  = w;
    adr[i][m] = a;
    wd[i][m]  = d;
  endtask

  // One clock: check everything at the falling edge, advance the model on
  // the rising edge, return 1ns after it so the caller can drive inputs.
  task automatic tick(output logic [3:0] g_o);
    int eo;
    logic [31:0] ed;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      pk[i] = pick(i);
      check($sformatf("i%0d_c%0d_m0_gnt", i, cyc), gnt[i][0], pk[i] == 0);
      check($sformatf("i%0d_c%0d_m1_gnt", i, cyc), gnt[i][1], pk[i] == 1);
      check($sformatf("i%0d_c%0d_bus_we", i, cyc), bwe[i], e_we[i]);
      check($sformatf("i%0d_c%0d_bus_ren", i, cyc), bren[i], e_ren[i]);
      check($sformatf("i%0d_c%0d_bus_wadr", i, cyc), bwadr[i], e_wadr[i]);
      check($sformatf("i%0d_c%0d_bus_wdata", i, cyc), bwdata[i], e_wdata[i]);
      check($sformatf("i%0d_c%0d_bus_radr", i, cyc), bradr[i], e_radr[i]);
      eo = -1;
      ed = '0;
      if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
        eo = rq[i][0].own;
        ed = rq[i][0].d;
        void'(rq[i].pop_front());
      end
      for (int m = 0; m < 2; m++) begin
        check($sformatf("i%0d_c%0d_m%0d_rvalid", i, cyc, m), rv[i][m], eo == m);
        if (eo == m) check($sformatf("i%0d_c%0d_m%0d_rdata", i, cyc, m), rd[i][m], ed);
        obs_rv[i][m] = rv[i][m];
        obs_rd[i][m] = rd[i][m];
        g_o[i*2+m]   = gnt[i][m];
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rq[i].delete();
        last_m[i] = 1;
        e_we[i]   = 1'b0;
        e_ren[i]  = 1'b0;
      end else if (pk[i] >= 0) begin
        last_m[i] = pk[i];
        if (we[i][pk[i]]) begin
          refmem[i][adr[i][pk[i]][3:0]] = wd[i][pk[i]];
          e_we[i]    = 1'b1;
          e_ren[i]   = 1'b0;
          e_wadr[i]  = adr[i][pk[i]];
          e_wdata[i] = wd[i][pk[i]];
        end else begin
          rq[i].push_back('{cyc + 2, pk[i], refmem[i][adr[i][pk[i]][3:0]]});
          e_we[i]   = 1'b0;
          e_ren[i]  = 1'b1;
          e_radr[i] = adr[i][pk[i]];
        end
      end else begin
        e_we[i]  = 1'b0;
        e_ren[i] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  // Drop the request of whichever master was just granted.
  task automatic retire();
    for (int i = 0; i < 2; i++) if (pk[i] >= 0) req[i][pk[i]] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      tick(gob);
      retire();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) drive(i, m, 1'b0, 1'b0, '0, '0);
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(gob);
    tick(gob);
    rst_n = 1'b1;

    // 1: m0 write, on the bus the next cycle
    for (int i = 0; i < 2; i++) drive(i, 0, 1'b1, 1'b1, 14'h3F80, 32'h0000_0765);
    tick(gob);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t1_i%0d_m0_gnt", i), gob[i*2], 1'b1);
      check($sformatf("t1_i%0d_bus_we", i), bwe[i], 1'b1);
      check($sformatf("t1_i%0d_bus_wadr", i), bwadr[i], 14'h3F80);
      check($sformatf("t1_i%0d_bus_wdata", i), bwdata[i], 32'h0000_0765);
      check($sformatf("t1_i%0d_bus_ren", i), bren[i], 1'b0);
    end
    retire();
    tick(gob);

    // 2: m1 read of the freshly written register
    for (int i = 0; i < 2; i++) drive(i, 1, 1'b1, 1'b0, 14'h3F80, '0);
    tick(gob);
    retire();
    for (int i = 0; i < 2; i++) check($sformatf("t2_i%0d_bus_ren", i), bren[i], 1'b1);
    tick(gob);
    tick(gob);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t2_i%0d_m1_rvalid", i), obs_rv[i][1], 1'b1);
      check($sformatf("t2_i%0d_m1_rdata", i), obs_rd[i][1], 32'h0000_0765);
      check($sformatf("t2_i%0d_m0_rvalid", i), obs_rv[i][0], 1'b0);
    end

    // 3: both masters read continuously for 6 cycles
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b1, 1'b0, 14'h3F80, '0);
      drive(i, 1, 1'b1, 1'b0, 14'h3F81, '0);
    end
    for (int k = 0; k < 6; k++) begin
      tick(gob);
      check($sformatf("t3_k%0d_rr_m0_gnt", k), gob[0], (k % 2) == 0);
      check($sformatf("t3_k%0d_rr_m1_gnt", k), gob[1], (k % 2) == 1);
      for (int i = 0; i < 2; i++)
        if (pk[i] >= 0) drive(i, pk[i], 1'b1, 1'b0, 14'h3F80 + 14'(pk[i]), '0);
    end
    retire();
    drain(4);

    // 4: both requesting; fixed priority starves m1 until m0 lets go
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b1, 1'b1, 14'h3F82, $urandom);
      drive(i, 1, 1'b1, 1'b0, 14'h3F82, '0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(gob);
      check($sformatf("t4_k%0d_fp_m0_gnt", k), gob[2], 1'b1);
      check($sformatf("t4_k%0d_fp_m1_gnt", k), gob[3], 1'b0);
      for (int i = 0; i < 2; i++) begin
        if (pk[i] == 0 && k == 3) req[i][0] = 1'b0;
        else if (pk[i] == 0) drive(i, 0, 1'b1, 1'b1, 14'h3F82, $urandom);
        else if (pk[i] == 1) drive(i, 1, 1'b1, 1'b0, 14'h3F82, '0);
      end
    end
    tick(gob);
    check("t4_fp_m1_gnt_after_drop", gob[3], 1'b1);
    retire();
    drain(5);

    // 5: write then read of the same address on consecutive cycles
    for (int i = 0; i < 2; i++) drive(i, 0, 1'b1, 1'b1, 14'h3F85, 32'hA5A5_0001);
    tick(gob);
    retire();
    for (int i = 0; i < 2; i++) drive(i, 1, 1'b1, 1'b0, 14'h3F85, '0);
    tick(gob);
    retire();
    for (int i = 0; i < 2; i++) check($sformatf("t5_i%0d_bus_ren", i), bren[i], 1'b1);
    tick(gob);
    tick(gob);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t5_i%0d_m1_rvalid", i), obs_rv[i][1], 1'b1);
      check($sformatf("t5_i%0d_m1_rdata", i), obs_rd[i][1], 32'hA5A5_0001);
    end

    // 6: reset lands while a read is on the bus
    for (int i = 0; i < 2; i++) drive(i, 0, 1'b1, 1'b0, 14'h3F85, '0);
    tick(gob);
    retire();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_i%0d_async_ren", i), bren[i], 1'b0);
      check($sformatf("t6_i%0d_async_radr", i), bradr[i], 14'h0000);
      check($sformatf("t6_i%0d_async_wadr", i), bwadr[i], 14'h0000);
      check($sformatf("t6_i%0d_async_wdata", i), bwdata[i], 32'h0);
      check($sformatf("t6_i%0d_async_we", i), bwe[i], 1'b0);
    end
    tick(gob);
    tick(gob);
    rst_n = 1'b1;
    tick(gob);
    tick(gob);
    tick(gob);
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b1, 1'b0, 14'h3F86, '0);
      drive(i, 1, 1'b1, 1'b0, 14'h3F87, '0);
    end
    tick(gob);
    check("t6_rr_tie_m0", gob[0], 1'b1);
    check("t6_rr_tie_m1", gob[1], 1'b0);
    retire();
    drain(4);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        for (int m = 0; m < 2; m++)
          if (!req[i][m] || pk[i] == m) begin
            if ($urandom_range(0, 99) < 65)
              drive(i, m, 1'b1, 1'($urandom_range(0, 1)),
                    14'h3F80 | 14'($urandom_range(0, 15)), $urandom);
            else
              req[i][m] = 1'b0;
          end
      tick(gob);
    end
    retire();
    drain(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
